// File: rtl/core_status_handshake_tx.sv
// core_status_handshake_tx
//
// Carries the core's final status (PC and exception bitmask) to the SoC.
// The SoC clock may be slower than the CPU clock, so the payload uses a
// 4-phase req/ack handshake:
//   - The payload is held stable while soc_req is high.
//   - The returning soc_ack passes through a 2-FF synchronizer.
//   - One event can be buffered while a handshake is in flight.
//
// Ports:
//   clk            in   CPU clock; all state updates on the rising edge
//   rst_n          in   synchronous, active-low reset
//   done_valid     in   single-cycle completion/trap event from the core
//   done_pc        in   PC of the event, valid with done_valid
//   done_exception in   exception bitmask of the event (0 = normal end)
//   soc_ack        in   acknowledge from the SoC domain (asynchronous)
//   soc_req        out  request; soc_pc/soc_exception are valid while high
//   soc_pc         out  transmitted PC, changes only at a launch
//   soc_exception  out  transmitted exception bitmask, changes only at a launch
//   tx_busy        out  handshake in flight or pending slot occupied
//   tx_overflow    out  sticky: an event was dropped (cleared by reset only)

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef EXCEPTION_NUM
`define EXCEPTION_NUM 8
`endif

module core_status_handshake_tx (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      done_valid,
  input  logic [`PC_WIDTH-1:0]      done_pc,
  input  logic [`EXCEPTION_NUM-1:0] done_exception,
  input  logic                      soc_ack,
  output logic                      soc_req,
  output logic [`PC_WIDTH-1:0]      soc_pc,
  output logic [`EXCEPTION_NUM-1:0] soc_exception,
  output logic                      tx_busy,
  output logic                      tx_overflow
);

  localparam int PW = `PC_WIDTH;
  localparam int EW = `EXCEPTION_NUM;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding
    REQ     = 2'd1,  // soc_req high, waiting for ack_sync = 1
    RELEASE = 2'd2   // soc_req low, waiting for ack_sync = 0
  } state_t;

  state_t          state;
  state_t          state_nx;

  // Ack synchronizer. Only ack_sync is used by the control logic.
  logic            ack_ff1;
  logic            ack_sync;

  // One-entry pending slot.
  logic            pend_valid;
  logic [PW-1:0]   pend_pc;
  logic [EW-1:0]   pend_exc;

  logic            launch;
  logic            launch_pend;
  logic            launch_direct;
  logic            store_evt;
  logic            drop_evt;
  logic            pend_valid_nx;

  // ---------------------------------------------------------------------------
  // Next-state / event-routing decode.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    launch        = 1'b0;
    launch_pend   = 1'b0;
    launch_direct = 1'b0;
    store_evt     = 1'b0;
    drop_evt      = 1'b0;
    pend_valid_nx = pend_valid;
    state_nx      = state;

    // A new request may start only once the previous ack has been seen low.
    // This also blocks a stale ack that is still high after reset.
    launch = ((state == IDLE) || (state == RELEASE)) && !ack_sync &&
             (pend_valid || done_valid);

    // The pending entry is older than a new event, so it goes out first.
    launch_pend   = launch && pend_valid;
    launch_direct = launch && !pend_valid;

    // An event that is not sent directly goes to the slot if the slot is
    // empty or is being emptied by this cycle's launch. Otherwise the newest
    // event is the one lost.
    if (done_valid && !launch_direct) begin
      if (!pend_valid || launch_pend) begin
        store_evt = 1'b1;
      end else begin
        drop_evt  = 1'b1;
      end
    end

    if (store_evt) begin
      pend_valid_nx = 1'b1;
    end else if (launch_pend) begin
      pend_valid_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (launch) state_nx = REQ;
      end
      REQ: begin
        if (ack_sync) state_nx = RELEASE;
      end
      RELEASE: begin
        // From RELEASE a launch goes straight back to REQ.
        if (launch)         state_nx = REQ;
        else if (!ack_sync) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the payload and slot data registers are reset as well. The
      // outputs then show 0 after reset rather than stale contents. This
      // matters because soc_pc/soc_exception are observable even while
      // soc_req is low.
      state         <= IDLE;
      ack_ff1       <= 1'b0;
      ack_sync      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_pc       <= '0;
      pend_exc      <= '0;
      soc_req       <= 1'b0;
      soc_pc        <= '0;
      soc_exception <= '0;
      tx_busy       <= 1'b0;
      tx_overflow   <= 1'b0;
    end else begin
      ack_ff1  <= soc_ack;
      ack_sync <= ack_ff1;

      state    <= state_nx;
      soc_req  <= (state_nx == REQ);

      // The payload changes only at a launch. It stays stable through REQ,
      // RELEASE and IDLE until the next one.
      if (launch) begin
        if (launch_pend) begin
          soc_pc        <= pend_pc;
          soc_exception <= pend_exc;
        end else begin
          soc_pc        <= done_pc;
          soc_exception <= done_exception;
        end
      end

      if (store_evt) begin
        pend_pc  <= done_pc;
        pend_exc <= done_exception;
      end
      pend_valid <= pend_valid_nx;

      if (drop_evt) tx_overflow <= 1'b1;

      tx_busy <= (state_nx != IDLE) || pend_valid_nx;
    end
  end

endmodule

// File: tb/tb_core_status_handshake_tx.sv
// Testbench for core_status_handshake_tx.
// A linear directed sequence drives events and acks.
// The expected payloads are queued in arrival order.
// A monitor pops one entry on each rising edge of soc_req.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef EXCEPTION_NUM
`define EXCEPTION_NUM 8
`endif

module tb_core_status_handshake_tx;

  localparam int PW = `PC_WIDTH;
  localparam int EW = `EXCEPTION_NUM;

  logic          clk;
  logic          rst_n;
  logic          done_valid;
  logic [PW-1:0] done_pc;
  logic [EW-1:0] done_exception;
  logic          soc_ack;
  logic          soc_req;
  logic [PW-1:0] soc_pc;
  logic [EW-1:0] soc_exception;
  logic          tx_busy;
  logic          tx_overflow;

  int checks;
  int failures;

  logic [PW+EW-1:0] exp_q[$];

  core_status_handshake_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .done_valid     (done_valid),
    .done_pc        (done_pc),
    .done_exception (done_exception),
    .soc_ack        (soc_ack),
    .soc_req        (soc_req),
    .soc_pc         (soc_pc),
    .soc_exception  (soc_exception),
    .tx_busy        (tx_busy),
    .tx_overflow    (tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one event for exactly one edge and record what should reach the SoC.
  task automatic send(input logic [PW-1:0] pc, input logic [EW-1:0] exc, input bit expect_tx);
    done_valid     = 1'b1;
    done_pc        = pc;
    done_exception = exc;
    if (expect_tx) exp_q.push_back({pc, exc});
    step();
    done_valid     = 1'b0;
  endtask

  // Raise ack until soc_req drops (3 edges), then lower it and wait until
  // ack_sync is low (2 edges). A pending item launches at the next edge.
  task automatic ack_cycle();
    soc_ack = 1'b1;
    step(3);
    check("ack_req_low", 64'(soc_req), 64'd0);
    soc_ack = 1'b0;
    step(2);
  endtask

  // Monitor: checks the payload on each new request and its stability while
  // the request is held high.
  logic          prev_req;
  logic [PW-1:0] prev_pc;
  logic [EW-1:0] prev_exc;
  logic [PW+EW-1:0] exp_item;

  always @(negedge clk) begin
    if (rst_n) begin
      if (soc_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_req", 64'(soc_pc), 64'hDEAD);
        end else begin
          exp_item = exp_q.pop_front();
          check("sb_pc",  64'(soc_pc),        64'(exp_item[PW+EW-1:EW]));
          check("sb_exc", 64'(soc_exception), 64'(exp_item[EW-1:0]));
        end
      end else if (soc_req && prev_req) begin
        check("stable_pc",  64'(soc_pc),        64'(prev_pc));
        check("stable_exc", 64'(soc_exception), 64'(prev_exc));
      end
    end
    prev_req = soc_req;
    prev_pc  = soc_pc;
    prev_exc = soc_exception;
  end

  initial begin
    checks         = 0;
    failures       = 0;
    prev_req       = 1'b0;
    prev_pc        = '0;
    prev_exc       = '0;
    rst_n          = 1'b0;
    done_valid     = 1'b0;
    done_pc        = '0;
    done_exception = '0;
    soc_ack        = 1'b0;

    // Reset state.
    step(2);
    rst_n = 1'b1;
    check("rst_req",      64'(soc_req),       64'd0);
    check("rst_pc",       64'(soc_pc),        64'd0);
    check("rst_exc",      64'(soc_exception), 64'd0);
    check("rst_busy",     64'(tx_busy),       64'd0);
    check("rst_overflow", 64'(tx_overflow),   64'd0);
    step(2);

    // Single event: one-cycle launch latency; req falls on the 3rd edge after ack.
    send(PW'(32'h0000_0100), '0, 1'b1);
    check("single_req", 64'(soc_req), 64'd1);
    check("single_pc",  64'(soc_pc),   64'h100);
    soc_ack = 1'b1;
    step(2);
    check("single_req_held", 64'(soc_req), 64'd1);
    step();
    check("single_req_fall", 64'(soc_req), 64'd0);
    soc_ack = 1'b0;
    step(2);
    check("single_busy_release", 64'(tx_busy), 64'd1);
    step();
    check("single_idle_busy", 64'(tx_busy), 64'd0);

    // Back-to-back events: the second event waits in the slot.
    send(PW'(32'h10), '0, 1'b1);
    send(PW'(32'h20), '0, 1'b1);
    check("b2b_pc_first", 64'(soc_pc),  64'h10);
    check("b2b_busy",     64'(tx_busy), 64'd1);
    ack_cycle();
    check("b2b_no_early_launch", 64'(soc_req), 64'd0);
    step();
    check("b2b_second_req", 64'(soc_req), 64'd1);
    check("b2b_second_pc",  64'(soc_pc),  64'h20);
    ack_cycle();
    step();
    check("b2b_idle", 64'(tx_busy), 64'd0);

    // Overflow: the third event arrives with the slot full.
    send(PW'(32'h10), '0, 1'b1);
    send(PW'(32'h20), '0, 1'b1);
    check("ovf_before", 64'(tx_overflow), 64'd0);
    send(PW'(32'h30), '0, 1'b0);
    check("ovf_set", 64'(tx_overflow), 64'd1);
    ack_cycle();
    step();
    check("ovf_second_pc", 64'(soc_pc), 64'h20);
    ack_cycle();
    step();
    check("ovf_idle",     64'(tx_busy),     64'd0);
    check("ovf_sticky",   64'(tx_overflow), 64'd1);
    check("ovf_req_none", 64'(soc_req),     64'd0);

    // Slot refill: a new event arrives in the same cycle the pending one launches.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("refill_ovf_cleared", 64'(tx_overflow), 64'd0);
    send(PW'(32'h10), '0, 1'b1);
    send(PW'(32'h20), '0, 1'b1);
    ack_cycle();
    send(PW'(32'h30), '0, 1'b1);
    check("refill_req",  64'(soc_req),     64'd1);
    check("refill_pc",   64'(soc_pc),      64'h20);
    check("refill_busy", 64'(tx_busy),     64'd1);
    check("refill_ovf",  64'(tx_overflow), 64'd0);
    ack_cycle();
    step();
    check("refill_third_pc", 64'(soc_pc), 64'h30);
    ack_cycle();
    step();
    check("refill_idle",    64'(tx_busy),     64'd0);
    check("refill_ovf_end", 64'(tx_overflow), 64'd0);

    // Stale ack: reset mid-handshake while the ack is still high.
    send(PW'(32'h50), '0, 1'b1);
    soc_ack = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("stale_req_reset", 64'(soc_req), 64'd0);
    step(2);
    send(PW'(32'h40), '0, 1'b1);
    check("stale_no_launch", 64'(soc_req), 64'd0);
    check("stale_busy",      64'(tx_busy), 64'd1);
    step(3);
    check("stale_still_low", 64'(soc_req), 64'd0);
    soc_ack = 1'b0;
    step(2);
    check("stale_wait_sync", 64'(soc_req), 64'd0);
    step();
    check("stale_launch", 64'(soc_req), 64'd1);
    check("stale_pc",     64'(soc_pc),  64'h40);
    ack_cycle();
    step();

    // Exception payload persists after the handshake completes.
    send(PW'(32'hFFFF_FFFC), EW'(4), 1'b1);
    check("exc_pc",  64'(soc_pc),        64'(PW'(32'hFFFF_FFFC)));
    check("exc_val", 64'(soc_exception), 64'd4);
    ack_cycle();
    step(3);
    check("exc_idle",         64'(tx_busy),       64'd0);
    check("exc_pc_persist",   64'(soc_pc),        64'(PW'(32'hFFFF_FFFC)));
    check("exc_val_persist",  64'(soc_exception), 64'd4);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
